smi_mem_lib_fuzz_test_sequencer: RTL

Multi-region sequencer that sits directly upstream of the 64-bit SMI memory burst fuzz tester. It accepts one start command and walks a run of contiguous, equal-sized memory regions, issuing one fuzz-tester configuration per region. It collects each region's error-count status and reports a single aggregated result. It includes a per-region watchdog, so a hung memory path ends the run with a timeout result instead of stalling forever.

---
 rtl/smi_mem_lib_fuzz_test_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/smi_mem_lib_fuzz_test_sequencer.sv
// Walks a run of contiguous equal-sized regions, issuing one fuzz-tester config
// per region and folding each region's error count into one aggregated result.
module smi_mem_lib_fuzz_test_sequencer #(
   parameter int                      TimeoutWidth  = 24,
   parameter logic [TimeoutWidth-1:0] TimeoutCycles = 24'hFFFFFF
) (
   input  logic        clk,
   input  logic        srst,
   input  logic        startValid,
   input  logic [63:0] startAddrBase,
   input  logic [31:0] startBlockSize,
   input  logic [31:0] startNumTests,
   input  logic [15:0] startNumRegions,
   output logic        startStop,
   output logic        configValid,
   output logic [63:0] configMemAddrBase,
   output logic [31:0] configMemBlockSize,
   output logic [31:0] configNumTests,
   input  logic        configStop,
   input  logic        statusValid,
   input  logic [31:0] statusErrorCount,
   output logic        statusStop,
   output logic        resultValid,
   output logic [31:0] resultErrorTotal,
   output logic [15:0] resultFailCount,
   output logic [15:0] resultFirstFail,
   output logic        resultTimeout,
   input  logic        resultStop
);

   typedef enum logic [2:0] {
      S_RESET,
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_REPORT
   } state_t;

   state_t state_q, state_d;

   logic [63:0]             addr_q, addr_d;
   logic [31:0]             block_q, block_d;
   logic [31:0]             tests_q, tests_d;
   logic [15:0]             num_regions_q, num_regions_d;
   logic [15:0]             region_idx_q, region_idx_d;
   logic [31:0]             err_total_q, err_total_d;
   logic [15:0]             fail_count_q, fail_count_d;
   logic [15:0]             first_fail_q, first_fail_d;
   logic                    timeout_q, timeout_d;
   logic [TimeoutWidth-1:0] wd_q, wd_d;

   logic [32:0] err_sum;
   logic [16:0] idx_inc;

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q <= S_RESET;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath is only meaningful once a start is accepted, so it carries no reset.
   always_ff @(posedge clk) begin
      addr_q        <= addr_d;
      block_q       <= block_d;
      tests_q       <= tests_d;
      num_regions_q <= num_regions_d;
      region_idx_q  <= region_idx_d;
      err_total_q   <= err_total_d;
      fail_count_q  <= fail_count_d;
      first_fail_q  <= first_fail_d;
      timeout_q     <= timeout_d;
      wd_q          <= wd_d;
   end

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      block_d       = block_q;
      tests_d       = tests_q;
      num_regions_d = num_regions_q;
      region_idx_d  = region_idx_q;
      err_total_d   = err_total_q;
      fail_count_d  = fail_count_q;
      first_fail_d  = first_fail_q;
      timeout_d     = timeout_q;
      wd_d          = wd_q;
      err_sum       = {1'b0, err_total_q} + {1'b0, statusErrorCount};
      idx_inc       = {1'b0, region_idx_q} + 17'd1;

      case (state_q)
         S_RESET: begin
            state_d = S_IDLE;
         end
         S_IDLE: begin
            if (startValid) begin
               addr_d        = startAddrBase;
               block_d       = startBlockSize;
               tests_d       = startNumTests;
               num_regions_d = startNumRegions;
               region_idx_d  = 16'd0;
               err_total_d   = 32'd0;
               fail_count_d  = 16'd0;
               first_fail_d  = 16'hFFFF;
               timeout_d     = 1'b0;
               state_d       = (startNumRegions == 16'd0) ? S_REPORT : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!configStop) begin
               wd_d    = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            wd_d = wd_q + 1'b1;
            // A status arriving on the watchdog's final cycle still counts.
            if (statusValid) begin
               err_total_d = err_sum[32] ? 32'hFFFFFFFF : err_sum[31:0];
               if (statusErrorCount != 32'd0) begin
                  fail_count_d = fail_count_q + 16'd1;
                  if (first_fail_q == 16'hFFFF) begin
                     first_fail_d = region_idx_q;
                  end
               end
               if (idx_inc == {1'b0, num_regions_q}) begin
                  state_d = S_REPORT;
               end else begin
                  region_idx_d = idx_inc[15:0];
                  addr_d       = addr_q + {32'd0, block_q};
                  state_d      = S_ISSUE;
               end
            end else if ((TimeoutCycles != '0) && (wd_q == TimeoutCycles)) begin
               timeout_d = 1'b1;
               state_d   = S_REPORT;
            end
         end
         S_REPORT: begin
            if (!resultStop) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Handshake outputs decode purely from the state register.
   assign startStop          = (state_q != S_IDLE);
   assign statusStop         = !((state_q == S_IDLE) || (state_q == S_WAIT));
   assign configValid        = (state_q == S_ISSUE);
   assign resultValid        = (state_q == S_REPORT);
   assign configMemAddrBase  = addr_q;
   assign configMemBlockSize = block_q;
   assign configNumTests     = tests_q;
   assign resultErrorTotal   = err_total_q;
   assign resultFailCount    = fail_count_q;
   assign resultFirstFail    = first_fail_q;
   assign resultTimeout      = timeout_q;

endmodule
